// File: rtl/cpu_ex_param.sv
// Execute/write-back stage: register file, condition evaluation, ALU, jump
// resolution with a flush window, and a req/ack data-memory port with range check.
module cpu_ex_param #(
  parameter int DW           = 32,
  parameter int RW           = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          id_valid,
  input  logic [DW-1:0] pc_id,
  input  logic [3:0]    cond,
  input  logic [3:0]    alu_op,
  input  logic [RW-1:0] ra_sel,
  input  logic [RW-1:0] rb_sel,
  input  logic          rb_imm_sel,
  input  logic [DW-1:0] imm,
  input  logic [RW-1:0] rd_sel,
  input  logic          rd_we,
  input  logic          flag_we,
  input  logic [2:0]    jump_sel,
  input  logic          mem_op,
  input  logic          mem_we,
  input  logic [DW-1:0] dmem_base,
  input  logic [DW-1:0] dmem_high,
  output logic          dmem_req,
  output logic          dmem_we_o,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] pc_link,
  output logic [3:0]    flags,
  output logic          flush,
  output logic          mem_fault,
  output logic          busy,
  input  logic [RW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 2**RW;
  localparam int SHW  = $clog2(DW);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] pc_q, pc_d, link_q, link_d;
  logic [3:0]    flags_q, flags_d;
  logic [2:0]    fcnt_q, fcnt_d;
  logic          req_q, req_d, we_q, we_d, fault_q, fault_d;
  logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [RW-1:0] rd_q, rd_d;

  logic [DW-1:0] op_a, op_b, alu_res;
  logic [DW:0]   sum;
  logic [SHW-1:0] sh;
  logic          cin, alu_c, alu_v, alu_cv, cond_ok, in_window, exec;
  logic          fz, fc, fv, fn;

  assign {fz, fc, fv, fn} = flags_q;

  always_comb begin
    op_a    = regs_q[ra_sel];
    op_b    = rb_imm_sel ? imm : regs_q[rb_sel];
    sh      = op_b[SHW-1:0];
    cin     = (alu_op == 4'd10) & fc;
    sum     = '0;
    alu_res = '0;
    alu_c   = fc;
    alu_v   = fv;
    alu_cv  = 1'b0;
    case (alu_op)
      4'd0: alu_res = op_b;
      4'd1, 4'd10: begin
        sum     = {1'b0, op_a} + {1'b0, op_b} + (DW+1)'(cin);
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (op_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
        alu_cv  = 1'b1;
      end
      4'd2, 4'd11: begin
        // The 33rd bit of the extended difference is the borrow; C is its inverse.
        sum     = {1'b0, op_a} - {1'b0, op_b};
        alu_res = sum[DW-1:0];
        alu_c   = ~sum[DW];
        alu_v   = (op_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
        alu_cv  = 1'b1;
      end
      4'd3: alu_res = op_a & op_b;
      4'd4: alu_res = op_a | op_b;
      4'd5: alu_res = op_a ^ op_b;
      4'd6: alu_res = ~op_b;
      4'd7: alu_res = op_a << sh;
      4'd8: alu_res = op_a >> sh;
      4'd9: alu_res = $signed(op_a) >>> sh;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (cond)
      4'd0:  cond_ok = 1'b0;
      4'd1:  cond_ok = fz;
      4'd2:  cond_ok = ~fz;
      4'd3:  cond_ok = fc;
      4'd4:  cond_ok = ~fc;
      4'd5:  cond_ok = fn;
      4'd6:  cond_ok = ~fn;
      4'd7:  cond_ok = fv;
      4'd8:  cond_ok = ~fv;
      4'd9:  cond_ok = fc & ~fz;
      4'd10: cond_ok = ~fc | fz;
      4'd11: cond_ok = (fn == fv);
      4'd12: cond_ok = (fn != fv);
      4'd13: cond_ok = ~fz & (fn == fv);
      4'd14: cond_ok = fz | (fn != fv);
      default: cond_ok = 1'b1;
    endcase
  end

  assign in_window = (alu_res >= dmem_base) && (alu_res <= dmem_high);
  assign exec      = id_valid && cond_ok && (fcnt_q == 3'd0);

  // NOTE: every next-state signal gets its hold value first, so partial
  // assignments below never infer a latch.
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    pc_d    = pc_q;
    link_d  = link_q;
    flags_d = flags_q;
    fcnt_d  = fcnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    rd_d    = rd_q;
    if (state_q == S_MEM_WAIT) begin
      if (dmem_ack) begin
        req_d   = 1'b0;
        pc_d    = pc_q + DW'(1);
        state_d = S_RUN;
        if (!we_q) regs_d[rd_q] = dmem_rdata;
      end
    end else if (!stall_i) begin
      if (!exec) begin
        pc_d = pc_q + DW'(1);
        if (fcnt_q != 3'd0) fcnt_d = fcnt_q - 3'd1;
      end else begin
        if (flag_we) flags_d = {alu_res == '0, alu_cv ? alu_c : fc,
                                alu_cv ? alu_v : fv, alu_res[DW-1]};
        if (rd_we && alu_op != 4'd11) regs_d[rd_sel] = alu_res;
        if (mem_op) begin
          if (in_window) begin
            addr_d  = alu_res;
            wdata_d = regs_q[rd_sel];
            we_d    = mem_we;
            rd_d    = rd_sel;
            req_d   = 1'b1;
            state_d = S_MEM_WAIT;
          end else begin
            fault_d = 1'b1;
            pc_d    = pc_q + DW'(1);
          end
        end else begin
          case (jump_sel)
            3'b001: pc_d = pc_q;
            3'b010: pc_d = pc_id + imm;
            3'b011: pc_d = pc_id - imm;
            3'b100: pc_d = op_a;
            default: pc_d = pc_q + DW'(1);
          endcase
          if (jump_sel inside {3'b010, 3'b011, 3'b100}) begin
            link_d = pc_id;
            fcnt_d = 3'(FLUSH_CYCLES);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      // NOTE: the register file is architecturally cleared by reset, so it is
      // built from flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pc_q    <= '0;
      link_q  <= '0;
      flags_q <= '0;
      fcnt_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      flags_q <= flags_d;
      fcnt_q  <= fcnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      rd_q    <= rd_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we_o  = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign pc         = pc_q;
  assign pc_link    = link_q;
  assign flags      = flags_q;
  assign flush      = (fcnt_q != 3'd0);
  assign mem_fault  = fault_q;
  assign busy       = (state_q == S_MEM_WAIT);
  assign dbg_data   = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_ex_param.sv
// Bench for cpu_ex_param: directed scenarios followed by random instructions,
// all compared against an instruction-level reference model.
module tb_cpu_ex_param;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk, rst, stall_i, id_valid;
  logic [31:0] pc_id, imm, dmem_base, dmem_high, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  cond, alu_op, flags;
  logic [4:0]  ra_sel, rb_sel, rd_sel, dbg_sel;
  logic        rb_imm_sel, rd_we, flag_we, mem_op, mem_we;
  logic [2:0]  jump_sel;
  logic        dmem_req, dmem_we_o, dmem_ack, flush, mem_fault, busy;
  logic [31:0] pc, pc_link, dbg_data;

  cpu_ex_param #(.DW(32), .RW(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .id_valid(id_valid), .pc_id(pc_id),
    .cond(cond), .alu_op(alu_op), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .rb_imm_sel(rb_imm_sel), .imm(imm), .rd_sel(rd_sel), .rd_we(rd_we),
    .flag_we(flag_we), .jump_sel(jump_sel), .mem_op(mem_op), .mem_we(mem_we),
    .dmem_base(dmem_base), .dmem_high(dmem_high), .dmem_req(dmem_req),
    .dmem_we_o(dmem_we_o), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .pc_link(pc_link),
    .flags(flags), .flush(flush), .mem_fault(mem_fault), .busy(busy),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  bit [31:0] m_regs [32];
  bit [31:0] m_pc, m_link, m_addr, m_wdata;
  bit        m_z, m_c, m_v, m_n, m_busy, m_we, m_fault;
  int        m_flush;
  bit [4:0]  m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] cc);
    case (cc)
      4'd0:  return 1'b0;
      4'd1:  return m_z;
      4'd2:  return !m_z;
      4'd3:  return m_c;
      4'd4:  return !m_c;
      4'd5:  return m_n;
      4'd6:  return !m_n;
      4'd7:  return m_v;
      4'd8:  return !m_v;
      4'd9:  return m_c && !m_z;
      4'd10: return !m_c || m_z;
      4'd11: return m_n == m_v;
      4'd12: return m_n != m_v;
      4'd13: return !m_z && (m_n == m_v);
      4'd14: return m_z || (m_n != m_v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_alu(input logic [3:0] op, input bit [31:0] a, input bit [31:0] b,
                           input bit cin, output bit [31:0] r, output bit c,
                           output bit v, output bit cv);
    longint unsigned ua, ub, full;
    longint sa, sb, s;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; c = 0; v = 0; cv = 0;
    case (op)
      4'd0: r = b;
      4'd1, 4'd10: begin
        full = ua + ub + ((op == 4'd10) ? cin : 0);
        s    = sa + sb + ((op == 4'd10) ? cin : 0);
        r = full[31:0]; c = full > 64'hFFFF_FFFF; v = (s > SMAX) || (s < SMIN); cv = 1;
      end
      4'd2, 4'd11: begin
        s = sa - sb;
        r = a - b; c = ua >= ub; v = (s > SMAX) || (s < SMIN); cv = 1;
      end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = ~b;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: r = $signed(a) >>> b[4:0];
      default: r = 0;
    endcase
  endtask

  // Predicts the state after the coming clock edge from the current inputs.
  task automatic model_cycle();
    bit [31:0] a, b, r;
    bit c, v, cv;
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_pc = 0; m_link = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
      {m_z, m_c, m_v, m_n} = 4'b0;
      m_busy = 0; m_we = 0; m_fault = 0; m_flush = 0;
      return;
    end
    if (m_busy) begin
      if (dmem_ack) begin
        if (!m_we) m_regs[m_rd] = dmem_rdata;
        m_pc++;
        m_busy = 0;
      end
      return;
    end
    if (stall_i) return;
    if (!(id_valid && cond_true(cond) && m_flush == 0)) begin
      m_pc++;
      if (m_flush > 0) m_flush--;
      return;
    end
    a = m_regs[ra_sel];
    b = rb_imm_sel ? imm : m_regs[rb_sel];
    model_alu(alu_op, a, b, m_c, r, c, v, cv);
    if (flag_we) begin
      m_z = (r == 0); m_n = r[31];
      if (cv) begin m_c = c; m_v = v; end
    end
    if (mem_op) begin
      if (r >= dmem_base && r <= dmem_high) begin
        m_busy = 1; m_addr = r; m_we = mem_we; m_wdata = m_regs[rd_sel]; m_rd = rd_sel;
      end else begin
        m_fault = 1; m_pc++;
      end
    end else begin
      case (jump_sel)
        3'b001: ;
        3'b010: m_pc = pc_id + imm;
        3'b011: m_pc = pc_id - imm;
        3'b100: m_pc = a;
        default: m_pc++;
      endcase
      if (jump_sel inside {3'b010, 3'b011, 3'b100}) begin
        m_link = pc_id; m_flush = 2;
      end
    end
    if (rd_we && alu_op != 4'd11) m_regs[rd_sel] = r;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("pc_link", pc_link, m_link);
    check("flags", flags, {m_z, m_c, m_v, m_n});
    check("flush", flush, m_flush != 0);
    check("mem_fault", mem_fault, m_fault);
    check("busy", busy, m_busy);
    check("dmem_req", dmem_req, m_busy);
    check("dmem_addr", dmem_addr, m_addr);
    check("dmem_we_o", dmem_we_o, m_we);
    check("dmem_wdata", dmem_wdata, m_wdata);
    check("dbg_reg", dbg_data, m_regs[dbg_sel]);
  endtask

  task automatic set_ins(input logic [3:0] cc, input logic [3:0] op, input logic [4:0] ra,
                         input logic [4:0] rb, input logic isel, input logic [31:0] iv,
                         input logic [4:0] rd, input logic we, input logic fwe,
                         input logic [2:0] jmp, input logic [31:0] pcid);
    id_valid = 1; cond = cc; alu_op = op; ra_sel = ra; rb_sel = rb; rb_imm_sel = isel;
    imm = iv; rd_sel = rd; rd_we = we; flag_we = fwe; jump_sel = jmp; pc_id = pcid;
    mem_op = 0; mem_we = 0; dbg_sel = rd;
  endtask

  initial begin
    rst = 0; stall_i = 0; dmem_ack = 0; dmem_rdata = 0;
    dmem_base = 32'h100; dmem_high = 32'h1FF;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 0;
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_flags", flags, 4'h0);
    rst = 1;

    // ADD overflow into the sign bit
    set_ins(15, 0, 0, 0, 1, 32'h7FFF_FFFF, 1, 1, 0, 0, 0); step();
    set_ins(15, 1, 1, 0, 1, 32'h1, 1, 1, 1, 0, 0); step();
    check("add_r1", dbg_data, 32'h8000_0000);
    check("add_flags_zcvn", flags, 4'b0011);
    check("add_pc", pc, 32'h2);

    // SUB to zero, then conditional taken jump and flush window
    set_ins(15, 2, 2, 2, 0, 0, 2, 1, 1, 0, 0); step();
    check("sub_flags_zcvn", flags, 4'b1100);
    set_ins(1, 0, 0, 0, 1, 32'h20, 0, 0, 0, 3'b010, 32'h10); step();
    check("jmp_pc", pc, 32'h30);
    check("jmp_link", pc_link, 32'h10);
    check("jmp_flush", flush, 1'b1);
    set_ins(15, 1, 1, 0, 1, 32'h1, 1, 1, 1, 0, 0); step();
    check("squash1_pc", pc, 32'h31);
    step();
    check("squash2_pc", pc, 32'h32);
    check("squash2_flush", flush, 1'b0);
    check("squash_r1", dbg_data, 32'h8000_0000);

    // CMP 5,7 then LT / GT moves
    set_ins(15, 0, 0, 0, 1, 32'd5, 6, 1, 0, 0, 0); step();
    set_ins(15, 11, 6, 0, 1, 32'd7, 6, 1, 1, 0, 0); step();
    check("cmp_no_write", dbg_data, 32'd5);
    check("cmp_flags_zcvn", flags, 4'b0001);
    set_ins(12, 0, 0, 0, 1, 32'd9, 3, 1, 0, 0, 0); step();
    check("lt_r3", dbg_data, 32'd9);
    set_ins(13, 0, 0, 0, 1, 32'd9, 4, 1, 0, 0, 0); step();
    check("gt_r4", dbg_data, 32'd0);

    // In-window load with ack on the third waiting cycle; stall must be ignored
    set_ins(15, 0, 0, 0, 1, 32'h180, 5, 1, 0, 0, 0);
    mem_op = 1; mem_we = 0;
    step();
    check("ld_req", dmem_req, 1'b1);
    check("ld_addr", dmem_addr, 32'h180);
    stall_i = 1; dmem_rdata = 32'hCAFE_F00D;
    step();
    step();
    check("ld_addr_stable", dmem_addr, 32'h180);
    dmem_ack = 1;
    step();
    dmem_ack = 0; stall_i = 0;
    check("ld_r5", dbg_data, 32'hCAFE_F00D);
    check("ld_done_busy", busy, 1'b0);

    // Out-of-window store faults, and the fault stays set
    set_ins(15, 0, 0, 0, 1, 32'h200, 5, 0, 0, 0, 0);
    mem_op = 1; mem_we = 1;
    step();
    check("st_fault", mem_fault, 1'b1);
    check("st_noreq", dmem_req, 1'b0);
    set_ins(15, 1, 3, 0, 1, 32'h1, 3, 1, 0, 0, 0); step();
    check("fault_sticky", mem_fault, 1'b1);

    // Stall freezes a valid ADD for four cycles
    set_ins(15, 1, 7, 0, 1, 32'h3, 7, 1, 1, 0, 0);
    stall_i = 1;
    repeat (4) step();
    check("stall_r7", dbg_data, 32'h0);
    stall_i = 0;
    step();
    check("unstall_r7", dbg_data, 32'h3);

    // Random instruction stream
    for (int k = 0; k < 600; k++) begin
      if (!m_busy) begin
        set_ins(($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 1'($urandom),
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                5'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000, $urandom);
        id_valid = ($urandom_range(0, 9) != 0);
        stall_i  = ($urandom_range(0, 9) == 0);
        dmem_ack = 0;
        if ($urandom_range(0, 7) == 0) begin
          mem_op = 1; mem_we = 1'($urandom); alu_op = 0; rb_imm_sel = 1;
          imm = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(32'h200, 32'h300))
                                            : 32'($urandom_range(32'h100, 32'h1FF));
        end
      end else begin
        dmem_ack   = ($urandom_range(0, 2) == 0);
        dmem_rdata = $urandom;
        stall_i    = 1'($urandom);
        dbg_sel    = m_rd;
      end
      step();
    end
    dmem_ack = 0;
    // Drain any outstanding access before the reset scenario
    for (int k = 0; k < 4 && m_busy; k++) begin
      dmem_ack = 1;
      step();
    end
    dmem_ack = 0; stall_i = 0;

    // Reset during MEM_WAIT; a late ack must not write anything
    set_ins(15, 0, 0, 0, 1, 32'h1A0, 9, 0, 0, 0, 0);
    mem_op = 1; mem_we = 0;
    step();
    check("rw_busy", busy, 1'b1);
    rst = 0;
    step();
    check("rw_req", dmem_req, 1'b0);
    check("rw_pc", pc, 32'h0);
    check("rw_busy_clr", busy, 1'b0);
    rst = 1; id_valid = 0; mem_op = 0; dmem_ack = 1; dmem_rdata = 32'h5A5A_5A5A; dbg_sel = 9;
    step();
    dmem_ack = 0;
    check("rw_r9", dbg_data, 32'h0);
    check("rw_pc_after", pc, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
